kl11_console: RTL and testbench

Console serial device on the I/O page: the KL11-compatible responder for the terminal registers the boot program polls (RCSR 177560, RBUF 177562, XCSR 177564, XBUF 177566). It decodes iopage reads and writes and serializes/deserializes 8N1 async characters on `txd`/`rxd`. It raises level interrupt requests for the interrupt controller. It sits beside the bootrom on the same iopage bus and uses the same read/decode conventions.

---
 rtl/kl11_pkg.sv | 27 ++
 rtl/kl11_console_if.sv | 12 +
 rtl/kl11_rx.sv | 63 ++++++
 rtl/kl11_console.sv | 126 ++++++++++++
 tb/tb_kl11_console.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/kl11_pkg.sv
// kl11_pkg: register map, bit positions and FSM state codes for the KL11 console
package kl11_pkg;
  localparam logic [12:0] RCSR_ADDR = 13'o17560;
  localparam logic [12:0] RBUF_ADDR = 13'o17562;
  localparam logic [12:0] XCSR_ADDR = 13'o17564;
  localparam logic [12:0] XBUF_ADDR = 13'o17566;
  localparam int DONE_BIT  = 7;
  localparam int IE_BIT    = 6;
  localparam int READY_BIT = 7;
  localparam int ERR_BIT   = 15;
  localparam int OR_BIT    = 14;
  localparam int FE_BIT    = 13;
  typedef logic [1:0] tx_state_t;
  localparam tx_state_t TX_IDLE  = 2'd0;
  localparam tx_state_t TX_START = 2'd1;
  localparam tx_state_t TX_DATA  = 2'd2;
  localparam tx_state_t TX_STOP  = 2'd3;
  typedef logic [2:0] rx_state_t;
  localparam rx_state_t RX_IDLE  = 3'd0;
  localparam rx_state_t RX_START = 3'd1;
  localparam rx_state_t RX_DATA  = 3'd2;
  localparam rx_state_t RX_STOP  = 3'd3;
  localparam rx_state_t RX_WAIT  = 3'd4;
  function automatic logic [12:0] word_addr(input logic [12:0] a);
    return {a[12:1], 1'b0};
  endfunction
endpackage

// File: rtl/kl11_console_if.sv
// kl11_console_if: iopage bus between the CPU side and the console registers
interface kl11_console_if;
  logic [12:0] iopage_addr;
  logic [15:0] data_in;
  logic        iopage_rd;
  logic        iopage_wr;
  logic        iopage_byte_op;
  logic [15:0] data_out;
  logic        decode;
  modport master(output iopage_addr, data_in, iopage_rd, iopage_wr, iopage_byte_op, input data_out, decode);
  modport slave(input iopage_addr, data_in, iopage_rd, iopage_wr, iopage_byte_op, output data_out, decode);
endinterface

// File: rtl/kl11_rx.sv
// kl11_rx: rxd synchronizer and 8N1 receive FSM producing one strobe per character
module kl11_rx import kl11_pkg::*; #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_fe,
  output logic       rx_strobe
);
  localparam int CW = $clog2(BAUD_DIV);
  logic s1, s2, s3;
  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] rx_bit;
  logic [7:0] sh;
  logic full;
  assign full = cnt == CW'(BAUD_DIV - 1);
  // two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge reset)
    if (reset) {s1, s2, s3} <= 3'b111;
    else {s1, s2, s3} <= {rxd, s1, s2};
  // start-bit qualification at mid-bit, then one sample per bit period
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RX_IDLE;
      cnt <= '0;
      rx_bit <= '0;
      sh <= '0;
      rx_data <= '0;
      rx_fe <= 1'b0;
      rx_strobe <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      case (state)
        RX_IDLE: if (s3 && !s2) begin
          state <= RX_START;
          cnt <= '0;
        end
        RX_START: if (cnt == CW'(BAUD_DIV / 2 - 1)) begin
          state <= s2 ? RX_IDLE : RX_DATA;
          cnt <= '0;
          rx_bit <= '0;
        end else cnt <= cnt + 1'b1;
        RX_DATA: if (full) begin
          sh <= {s2, sh[7:1]};
          cnt <= '0;
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) state <= RX_STOP;
        end else cnt <= cnt + 1'b1;
        RX_STOP: if (full) begin
          rx_data <= sh;
          rx_fe <= !s2;
          rx_strobe <= 1'b1;
          cnt <= '0;
          state <= s2 ? RX_IDLE : RX_WAIT;
        end else cnt <= cnt + 1'b1;
        RX_WAIT: if (s2) state <= RX_IDLE;
        default: state <= RX_IDLE;
      endcase
    end
endmodule

// File: rtl/kl11_console.sv
// kl11_console: KL11 terminal registers on the iopage with 8N1 transmitter and receiver
module kl11_console import kl11_pkg::*; #(
  parameter int BAUD_DIV = 434
) (
  input  logic           clk,
  input  logic           reset,
  kl11_console_if.slave  bus,
  input  logic           rxd,
  output logic           txd,
  output logic           rx_int,
  output logic           tx_int
);
  localparam int CW = $clog2(BAUD_DIV);
  logic [12:0] wa;
  logic rd, wr_lo, rd_rbuf, load;
  logic rx_done, rx_ie, rx_or, rx_fe_q;
  logic [7:0] rbuf;
  logic tx_ready, tx_ie;
  tx_state_t tx_state;
  logic [7:0] tx_sh;
  logic [2:0] tx_bit;
  logic [CW-1:0] tx_cnt;
  logic tx_step;
  logic [7:0] rx_data;
  logic rx_fe, rx_strobe;
  logic [15:0] word;
  kl11_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk(clk), .reset(reset), .rxd(rxd),
    .rx_data(rx_data), .rx_fe(rx_fe), .rx_strobe(rx_strobe)
  );
  assign wa = word_addr(bus.iopage_addr);
  assign bus.decode = bus.iopage_addr[12:3] == RCSR_ADDR[12:3];
  assign rd = bus.iopage_rd && bus.decode;
  assign wr_lo = bus.iopage_wr && bus.decode && !(bus.iopage_byte_op && bus.iopage_addr[0]);
  assign rd_rbuf = rd && wa == RBUF_ADDR;
  assign load = wr_lo && wa == XBUF_ADDR && tx_ready;
  assign tx_step = tx_cnt == CW'(BAUD_DIV - 1);
  assign rx_int = rx_done && rx_ie;
  assign tx_int = tx_ready && tx_ie;
  // register read mux; XBUF and undecoded offsets read as zero
  always_comb begin
    word = '0;
    if (wa == RCSR_ADDR) begin
      word[DONE_BIT] = rx_done;
      word[IE_BIT] = rx_ie;
    end
    if (wa == RBUF_ADDR) begin
      word[7:0] = rbuf;
      word[ERR_BIT] = rx_or || rx_fe_q;
      word[OR_BIT] = rx_or;
      word[FE_BIT] = rx_fe_q;
    end
    if (wa == XCSR_ADDR) begin
      word[READY_BIT] = tx_ready;
      word[IE_BIT] = tx_ie;
    end
    bus.data_out = !rd ? 16'd0 : !bus.iopage_byte_op ? word :
                   bus.iopage_addr[0] ? {8'd0, word[15:8]} : {8'd0, word[7:0]};
  end
  // receiver status: a new character beats a simultaneous RBUF read
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_done <= 1'b0;
      rx_or <= 1'b0;
      rx_fe_q <= 1'b0;
      rbuf <= '0;
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
    end else begin
      if (rx_strobe) begin
        rbuf <= rx_data;
        rx_fe_q <= rx_fe;
        rx_or <= rx_done && !rd_rbuf;
        rx_done <= 1'b1;
      end else if (rd_rbuf) begin
        rx_done <= 1'b0;
        rx_or <= 1'b0;
        rx_fe_q <= 1'b0;
      end
      if (wr_lo && wa == RCSR_ADDR) rx_ie <= bus.data_in[IE_BIT];
      if (wr_lo && wa == XCSR_ADDR) tx_ie <= bus.data_in[IE_BIT];
    end
  // transmitter: a pending character starts its frame one cycle after the XBUF write
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_state <= TX_IDLE;
      txd <= 1'b1;
      tx_ready <= 1'b1;
      tx_sh <= '0;
      tx_bit <= '0;
      tx_cnt <= '0;
    end else if (tx_state == TX_IDLE) begin
      if (load) begin
        tx_sh <= bus.data_in[7:0];
        tx_ready <= 1'b0;
      end else if (!tx_ready) begin
        tx_state <= TX_START;
        txd <= 1'b0;
        tx_cnt <= '0;
      end
    end else begin
      tx_cnt <= tx_step ? '0 : tx_cnt + 1'b1;
      if (tx_step)
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            txd <= tx_sh[0];
            tx_sh <= tx_sh >> 1;
            tx_bit <= '0;
          end
          TX_DATA: if (tx_bit == 3'd7) begin
            tx_state <= TX_STOP;
            txd <= 1'b1;
          end else begin
            txd <= tx_sh[0];
            tx_sh <= tx_sh >> 1;
            tx_bit <= tx_bit + 3'd1;
          end
          TX_STOP: begin
            tx_state <= TX_IDLE;
            tx_ready <= 1'b1;
          end
          default: tx_state <= TX_IDLE;
        endcase
    end
endmodule

// File: tb/tb_kl11_console.sv
// tb_kl11_console: register table, directed serial sequences and randomized frames against a frame-level model
module tb_kl11_console;
  import kl11_pkg::*;
  localparam int B = 4;
  logic clk = 0, reset = 0, rxd = 1;
  logic txd, rx_int, tx_int;
  int n_cmp = 0, n_bad = 0;
  kl11_console_if bus();
  kl11_console #(.BAUD_DIV(B)) dut (
    .clk(clk), .reset(reset), .bus(bus), .rxd(rxd),
    .txd(txd), .rx_int(rx_int), .tx_int(tx_int)
  );
  always #5 clk = ~clk;

  typedef struct {
    bit wr;
    bit bo;
    logic [12:0] a;
    logic [15:0] d;
    logic [15:0] exp;
    bit dec;
  } vec_t;
  vec_t tbl[20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [12:0] a, input logic [15:0] d, input bit bo);
    @(negedge clk);
    bus.iopage_addr = a;
    bus.data_in = d;
    bus.iopage_byte_op = bo;
    bus.iopage_wr = 1;
    @(negedge clk);
    bus.iopage_wr = 0;
  endtask

  task automatic bus_read(input logic [12:0] a, input bit bo, output logic [15:0] d, output logic dec);
    @(negedge clk);
    bus.iopage_addr = a;
    bus.iopage_byte_op = bo;
    bus.iopage_rd = 1;
    #1;
    d = bus.data_out;
    dec = bus.decode;
    @(negedge clk);
    bus.iopage_rd = 0;
  endtask

  task automatic read_check(input string name, input logic [12:0] a, input bit bo, input logic [15:0] exp);
    logic [15:0] d;
    logic dec;
    bus_read(a, bo, d, dec);
    check(name, d, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] c, input bit stop);
    logic [9:0] fr;
    fr = {stop, c, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (B) @(negedge clk);
    end
    rxd = 1;
  endtask

  // txd expected k cycles after the accepting write edge: one idle cycle, ten B-cycle bits, then idle
  function automatic bit tx_model(input logic [7:0] c, input int k);
    logic [9:0] fr;
    fr = {1'b1, c, 1'b0};
    if (k < 1 || k > 10 * B) return 1'b1;
    return fr[(k - 1) / B];
  endfunction

  task automatic tx_run(input logic [7:0] c, input logic [7:0] hi, input bit bo,
                        input int drop_at, input bit with_int, input string name);
    logic [44:0] got, exp, gi, ei;
    bus_write(XBUF_ADDR, {hi, c}, bo);
    for (int k = 0; k < 45; k++) begin
      if (k > 0) @(negedge clk);
      got[k] = txd;
      exp[k] = tx_model(c, k);
      gi[k] = tx_int;
      ei[k] = k >= 10 * B + 1;
      bus.iopage_wr = 0;
      if (k == drop_at) begin
        bus.iopage_addr = XBUF_ADDR;
        bus.data_in = 16'o000102;
        bus.iopage_byte_op = 0;
        bus.iopage_wr = 1;
      end
    end
    bus.iopage_wr = 0;
    check(name, got, exp);
    if (with_int) check({name, "_int"}, gi, ei);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic dec;
    logic [7:0] c, c2;
    bit st, done_m, or_m, fe_m;
    logic [7:0] last;
    logic [44:0] idl;
    tbl[0]  = '{0, 0, 13'o17560, 16'o0, 16'o000000, 1};
    tbl[1]  = '{0, 0, 13'o17562, 16'o0, 16'o000000, 1};
    tbl[2]  = '{0, 0, 13'o17564, 16'o0, 16'o000200, 1};
    tbl[3]  = '{0, 0, 13'o17566, 16'o0, 16'o000000, 1};
    tbl[4]  = '{0, 0, 13'o17570, 16'o0, 16'o000000, 0};
    tbl[5]  = '{0, 0, 13'o17556, 16'o0, 16'o000000, 0};
    tbl[6]  = '{1, 0, 13'o17560, 16'o177777, 16'o0, 1};
    tbl[7]  = '{0, 0, 13'o17560, 16'o0, 16'o000100, 1};
    tbl[8]  = '{1, 1, 13'o17561, 16'o000000, 16'o0, 1};
    tbl[9]  = '{0, 0, 13'o17560, 16'o0, 16'o000100, 1};
    tbl[10] = '{0, 1, 13'o17561, 16'o0, 16'o000000, 1};
    tbl[11] = '{1, 0, 13'o17562, 16'o177777, 16'o0, 1};
    tbl[12] = '{0, 0, 13'o17562, 16'o0, 16'o000000, 1};
    tbl[13] = '{1, 1, 13'o17564, 16'o000100, 16'o0, 1};
    tbl[14] = '{0, 1, 13'o17564, 16'o0, 16'o000300, 1};
    tbl[15] = '{0, 0, 13'o17564, 16'o0, 16'o000300, 1};
    tbl[16] = '{1, 0, 13'o17564, 16'o000000, 16'o0, 1};
    tbl[17] = '{1, 0, 13'o17560, 16'o000000, 16'o0, 1};
    tbl[18] = '{0, 0, 13'o17560, 16'o0, 16'o000000, 1};
    tbl[19] = '{0, 0, 13'o17564, 16'o0, 16'o000200, 1};
    bus.iopage_addr = '0;
    bus.data_in = '0;
    bus.iopage_rd = 0;
    bus.iopage_wr = 0;
    bus.iopage_byte_op = 0;
    #1 reset = 1;
    idle(3);
    reset = 0;
    // asynchronous reset in the middle of a start bit
    bus_write(XBUF_ADDR, 16'o000101, 0);
    idle(2);
    check("tx_start_low", txd, 0);
    #2 reset = 1;
    #1 check("reset_async_txd", txd, 1);
    check("reset_rx_int", rx_int, 0);
    check("reset_tx_int", tx_int, 0);
    @(negedge clk) reset = 0;
    read_check("reset_xcsr", XCSR_ADDR, 0, 16'o000200);
    read_check("reset_rcsr", RCSR_ADDR, 0, 16'o000000);
    read_check("reset_rbuf", RBUF_ADDR, 0, 16'o000000);
    // register map table
    for (int i = 0; i < 20; i++)
      if (tbl[i].wr) bus_write(tbl[i].a, tbl[i].d, tbl[i].bo);
      else begin
        bus_read(tbl[i].a, tbl[i].bo, d, dec);
        check($sformatf("vec%0d_data", i), d, tbl[i].exp);
        check($sformatf("vec%0d_decode", i), dec, tbl[i].dec);
      end
    // transmit interrupt and the 'A' frame
    bus_write(XCSR_ADDR, 16'o000100, 0);
    check("tx_int_on_ie", tx_int, 1);
    tx_run(8'o101, 8'h00, 0, -1, 1, "tx_A");
    read_check("xcsr_after_tx", XCSR_ADDR, 0, 16'o000300);
    bus_write(XCSR_ADDR, 16'o000000, 0);
    check("tx_int_off", tx_int, 0);
    // second write during a frame is dropped
    tx_run(8'o101, 8'h00, 0, 10, 0, "tx_drop");
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      idl[k] = txd;
    end
    check("tx_drop_idle", idl, 45'h1fff_ffff_ffff);
    // randomized transmit frames, word and low-byte writes
    for (int n = 0; n < 4; n++) begin
      c = 8'($urandom);
      tx_run(c, 8'($urandom), n[0], -1, 0, $sformatf("tx_rand%0d", n));
    end
    // receive 0x55
    send_char(8'h55, 1);
    idle(2 * B);
    read_check("rx55_rcsr", RCSR_ADDR, 0, 16'o000200);
    read_check("rx55_rbuf", RBUF_ADDR, 0, 16'o000125);
    read_check("rx55_rcsr_clr", RCSR_ADDR, 0, 16'o000000);
    // byte read of RBUF clears DONE
    send_char(8'h55, 1);
    idle(2 * B);
    read_check("rx_byte_rbuf", RBUF_ADDR, 1, 16'o000125);
    read_check("rx_byte_rcsr", RCSR_ADDR, 0, 16'o000000);
    // overrun then framing error
    send_char(8'h31, 1);
    send_char(8'h32, 1);
    idle(2 * B);
    read_check("rx_overrun", RBUF_ADDR, 0, 16'o140062);
    send_char(8'h33, 0);
    idle(2 * B);
    read_check("rx_fe_done", RCSR_ADDR, 0, 16'o000200);
    read_check("rx_framing", RBUF_ADDR, 0, 16'o120063);
    read_check("rx_fe_cleared", RCSR_ADDR, 0, 16'o000000);
    // one-cycle glitch
    @(negedge clk) rxd = 0;
    @(negedge clk) rxd = 1;
    idle(12 * B);
    read_check("rx_glitch", RCSR_ADDR, 0, 16'o000000);
    // receive interrupt
    bus_write(RCSR_ADDR, 16'o000100, 0);
    check("rx_int_idle", rx_int, 0);
    send_char(8'h5a, 1);
    idle(2 * B);
    check("rx_int_done", rx_int, 1);
    read_check("rx_int_rcsr", RCSR_ADDR, 0, 16'o000300);
    read_check("rx_int_rbuf", RBUF_ADDR, 0, 16'o000132);
    check("rx_int_clr", rx_int, 0);
    bus_write(RCSR_ADDR, 16'o000000, 0);
    // randomized receive against a status model
    done_m = 0;
    or_m = 0;
    fe_m = 0;
    last = 0;
    for (int n = 0; n < 10; n++) begin
      c = 8'($urandom);
      st = $urandom_range(0, 3) != 0;
      send_char(c, st);
      idle(2 * B);
      or_m = done_m;
      done_m = 1;
      fe_m = !st;
      last = c;
      read_check($sformatf("rxr%0d_rcsr", n), RCSR_ADDR, 0, {8'd0, done_m, 7'd0});
      if ($urandom_range(0, 1) == 1 || n == 9) begin
        read_check($sformatf("rxr%0d_rbuf", n), RBUF_ADDR, 0,
                   {or_m | fe_m, or_m, fe_m, 5'd0, last});
        done_m = 0;
      end
    end
    // simultaneous transmit and receive
    c = 8'($urandom);
    c2 = 8'($urandom);
    fork
      tx_run(c, 8'h00, 0, -1, 0, "tx_concurrent");
      send_char(c2, 1);
    join
    idle(2 * B);
    read_check("rx_concurrent", RBUF_ADDR, 0, {8'd0, c2});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
